mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
Shares the single data_ram256x8 instance between the instruction-fetch (IF) requester and the data-memory (MEM) stage requester. The block arbitrates between them, latches the winning request, and sequences the RAM's Enable/ReadWrite/Address/Size/DataIn pins. It returns registered read data, or a write acknowledge, through a grant/valid handshake. It also rejects misaligned and out-of-range accesses before they reach the RAM.

Parameters:
ACCESS_CYCLES, 1, number of consecutive cycles RamEnable is held high per access (1-15)
DEPTH, 256, RAM size in bytes; used for the range check

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
IfReq  in  1  IF read request (always a word read)
IfAddr  in  32  IF byte address
IfGnt  out  1  one-cycle pulse: IF request accepted and latched
IfValid  out  1  one-cycle pulse: IfData/IfFault valid
IfData  out  32  IF read data
IfFault  out  1  qualifies IfValid; access rejected
MemReq  in  1  MEM request
MemRW  in  1  0 = read, 1 = write
MemSize  in  2  00 = byte, 01 = half-word, 10 = word, 11 = reserved
MemAddr  in  32  MEM byte address
MemWData  in  32  MEM write data, right-justified
MemGnt  out  1  one-cycle pulse: MEM request accepted
MemValid  out  1  one-cycle pulse: read data or write acknowledge
MemRData  out  32  MEM read data, zero-extended
MemFault  out  1  qualifies MemValid; access rejected
RamEnable  out  1  to RAM Enable
RamReadWrite  out  1  to RAM ReadWrite (0 = read)
RamAddress  out  32  to RAM Address
RamDataIn  out  32  to RAM DataIn
RamSize  out  2  to RAM Size
RamDataOut  in  32  from RAM DataOut
Busy  out  1  high whenever state is not IDLE

Behaviour:
- One clock domain, clk. reset is synchronous and active-high.
- While reset is high:
  - state goes to IDLE.
  - Every output is driven to 0.
  - Any in-flight access is discarded: no Valid or Gnt is issued for it.
  - LastGrant is set to IF.
- States: IDLE -> SETUP -> ENABLE -> RESP -> IDLE. A faulting access goes IDLE -> RESP directly.
- Request rules:
  - A requester holds Req and its fields stable until its Gnt.
  - Fields are latched at the grant edge; Req may drop afterwards.
  - Req is ignored outside IDLE.
- IDLE arbitration:
  - A single requester wins immediately.
  - When both request, round-robin: the side opposite LastGrant wins. The first conflict after reset goes to MEM.
  - LastGrant updates on every grant.
  - The winner's Gnt is high in the cycle after the grant edge, i.e. the first SETUP or RESP cycle.
- Fault check, evaluated at the grant edge:
  - Size 11 faults.
  - Half-word with Addr[0] = 1 faults.
  - Word with Addr[1:0] != 0 faults.
  - Addr + bytes > DEPTH faults.
  - IF requests are checked as word accesses.
  - A faulted access never asserts RamEnable.
  - RESP then pulses Valid with Fault = 1 and data = 0.
- SETUP (1 cycle):
  - RamAddress, RamSize, RamReadWrite and RamDataIn are driven from the latched request.
  - RamEnable = 0.
  - RamDataIn = 0 for reads.
- ENABLE (exactly ACCESS_CYCLES cycles, down-counter):
  - RamEnable = 1; address, size and data stay stable.
  - On the edge leaving ENABLE, RamDataOut is captured into the response register, masked by size: byte keeps [7:0], half keeps [15:0], upper bits are 0.
  - For writes the captured data is 0.
- RESP (1 cycle):
  - RamEnable = 0, RamReadWrite = 0.
  - The owner's Valid = 1, with data and Fault.
  - Next state is IDLE.
- Latency:
  - Gnt in cycle C0, RamEnable in C1..C(ACCESS_CYCLES), Valid in C(ACCESS_CYCLES+1).
  - Fault: Gnt and Valid in the same cycle C0.
  - Back-to-back throughput: one access per ACCESS_CYCLES+3 cycles.
- Data outputs (IfData, MemRData, Fault flags) hold their last value until the next Valid. Only the Valid qualifies them.
- Reset during ENABLE: RamEnable is 0 in the cycle after the reset edge, and a partial write is acceptable. A RAM write is never re-issued.

Decomposition:
- Package mem_arb_pkg holds:
  - size encodings SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10
  - the state encoding
  - requester IDs REQ_IF / REQ_MEM
- Sub-module mem_align_check (combinational): takes address and size, returns the fault flag and the 32-bit read mask.
- It is instantiated once on the arbitration winner's fields.

Test Plan:
- RAM preloaded with word 0 = 0x11223344; IfReq with IfAddr = 0 (ACCESS_CYCLES = 1) -> IfGnt in C0, RamEnable high only in C1, IfValid in C2 with IfData = 0x11223344 and IfFault = 0.
- MEM write byte 0xA5 at address 5, then MEM read byte at address 5 -> RamReadWrite = 1 during the write's SETUP/ENABLE; the write's MemValid has MemRData = 0; the read returns MemRData = 0x000000A5.
- IfReq and MemReq held continuously for three grants -> grant order MEM, IF, MEM; never two Gnt pulses in the same cycle.
- MEM half-word read at address 3, then MEM word read at address 254 (DEPTH = 256) -> each gives MemGnt and MemValid in the same cycle with MemFault = 1 and MemRData = 0; RamEnable stays 0 throughout.
- reset asserted for one cycle during ENABLE of an IF read -> next cycle RamEnable = 0, Busy = 0, no IfValid; a following MemReq is served with normal latency.
- ACCESS_CYCLES = 3, MEM word read at address 8 -> RamEnable high for exactly 3 cycles (C1..C3), MemValid in C4.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IF/MEM RAM access arbiter.
package mem_arb_pkg;

    // Access size encodings, matching the RAM Size pins.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    // Arbiter states.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ENABLE = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Requester IDs, also the encoding of LastGrant.
    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    // Number of bytes touched by an access of the given size.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            default:   size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_arbiter_align.sv
// Combinational alignment/range check and read-data mask for one access.
module mem_align_check
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    output logic        fault,
    output logic [31:0] mask
);

    logic [32:0] end_addr;

    // Reject reserved sizes, misalignment, and accesses running past DEPTH.
    always_comb begin
        end_addr = {1'b0, addr} + {30'd0, size_bytes(size)};
        fault    = 1'b0;
        mask     = 32'd0;
        case (size)
            SIZE_BYTE: mask = 32'h0000_00FF;
            SIZE_HALF: begin
                mask  = 32'h0000_FFFF;
                fault = addr[0];
            end
            SIZE_WORD: begin
                mask  = 32'hFFFF_FFFF;
                fault = (addr[1:0] != 2'b00);
            end
            default:   fault = 1'b1;
        endcase
        if (end_addr > 33'(DEPTH)) begin
            fault = 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates the IF and MEM requesters onto one shared RAM port and
// sequences SETUP / ENABLE / RESP for the winning access.
//
// Handshake: a requester raises Req with stable fields and holds them until
// its Gnt pulse; fields are latched on the edge that produces Gnt, after
// which Req may drop. Valid is a one-cycle pulse qualifying Data and Fault,
// which otherwise hold their last value. Req is only looked at in IDLE.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = 1,
    parameter int DEPTH         = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IfReq,
    input  logic [31:0] IfAddr,
    output logic        IfGnt,
    output logic        IfValid,
    output logic [31:0] IfData,
    output logic        IfFault,
    input  logic        MemReq,
    input  logic        MemRW,
    input  logic [1:0]  MemSize,
    input  logic [31:0] MemAddr,
    input  logic [31:0] MemWData,
    output logic        MemGnt,
    output logic        MemValid,
    output logic [31:0] MemRData,
    output logic        MemFault,
    output logic        RamEnable,
    output logic        RamReadWrite,
    output logic [31:0] RamAddress,
    output logic [31:0] RamDataIn,
    output logic [1:0]  RamSize,
    input  logic [31:0] RamDataOut,
    output logic        Busy
);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        last_grant;
    logic        owner;
    logic        gnt_q;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] lat_mask;
    logic [1:0]  lat_size;
    logic        lat_rw;

    logic [31:0] if_data_q;
    logic [31:0] mem_data_q;
    logic        if_fault_q;
    logic        mem_fault_q;

    logic        win;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [1:0]  win_size;
    logic        win_rw;
    logic        win_fault;
    logic [31:0] win_mask;
    logic        grant;
    logic        fault_resp;
    logic        enable_done;
    logic [31:0] resp_data;
    logic        run;
    logic        drive;

    // Pick the winner: a lone requester wins, a conflict goes opposite LastGrant.
    always_comb begin
        if (IfReq && MemReq) begin
            win = (last_grant == REQ_IF) ? REQ_MEM : REQ_IF;
        end else if (MemReq) begin
            win = REQ_MEM;
        end else begin
            win = REQ_IF;
        end
        win_addr  = (win == REQ_MEM) ? MemAddr : IfAddr;
        win_size  = (win == REQ_MEM) ? MemSize : SIZE_WORD;
        win_rw    = (win == REQ_MEM) && MemRW;
        win_wdata = win_rw ? MemWData : 32'd0;
    end

    mem_align_check #(
        .DEPTH (DEPTH)
    ) u_align (
        .addr  (win_addr),
        .size  (win_size),
        .fault (win_fault),
        .mask  (win_mask)
    );

    assign grant       = (state == ST_IDLE) && (IfReq || MemReq);
    assign fault_resp  = grant && win_fault;
    assign enable_done = (state == ST_ENABLE) && (cnt == 4'd0);
    assign resp_data   = lat_rw ? 32'd0 : (RamDataOut & lat_mask);

    // Main FSM: latch the winner at the grant edge and step through the access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            last_grant <= REQ_IF;
            owner      <= REQ_IF;
            gnt_q      <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_mask   <= 32'd0;
            lat_size   <= SIZE_BYTE;
            lat_rw     <= 1'b0;
        end else begin
            gnt_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        owner      <= win;
                        last_grant <= win;
                        gnt_q      <= 1'b1;
                        lat_addr   <= win_addr;
                        lat_size   <= win_size;
                        lat_rw     <= win_rw;
                        lat_wdata  <= win_wdata;
                        lat_mask   <= win_mask;
                        state      <= win_fault ? ST_RESP : ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cnt   <= 4'(ACCESS_CYCLES - 1);
                    state <= ST_ENABLE;
                end
                ST_ENABLE: begin
                    if (cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Response registers: loaded when a response becomes visible, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_data_q   <= 32'd0;
            if_fault_q  <= 1'b0;
            mem_data_q  <= 32'd0;
            mem_fault_q <= 1'b0;
        end else if (fault_resp) begin
            if (win == REQ_MEM) begin
                mem_data_q  <= 32'd0;
                mem_fault_q <= 1'b1;
            end else begin
                if_data_q   <= 32'd0;
                if_fault_q  <= 1'b1;
            end
        end else if (enable_done) begin
            if (owner == REQ_MEM) begin
                mem_data_q  <= resp_data;
                mem_fault_q <= 1'b0;
            end else begin
                if_data_q   <= resp_data;
                if_fault_q  <= 1'b0;
            end
        end
    end

    // Every output is forced low while reset is asserted.
    assign run   = !reset;
    assign drive = run && ((state == ST_SETUP) || (state == ST_ENABLE));

    assign Busy         = run && (state != ST_IDLE);
    assign IfGnt        = run && gnt_q && (owner == REQ_IF);
    assign MemGnt       = run && gnt_q && (owner == REQ_MEM);
    assign IfValid      = run && (state == ST_RESP) && (owner == REQ_IF);
    assign MemValid     = run && (state == ST_RESP) && (owner == REQ_MEM);
    assign IfData       = run ? if_data_q : 32'd0;
    assign IfFault      = run && if_fault_q;
    assign MemRData     = run ? mem_data_q : 32'd0;
    assign MemFault     = run && mem_fault_q;
    assign RamEnable    = run && (state == ST_ENABLE);
    assign RamReadWrite = drive && lat_rw;
    assign RamAddress   = drive ? lat_addr : 32'd0;
    assign RamSize      = drive ? lat_size : SIZE_BYTE;
    assign RamDataIn    = drive ? lat_wdata : 32'd0;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: bench-side RAM, transaction-level model,
// per-cycle compare, directed scenarios, then randomized traffic.
module tb_mem_access_arbiter;

    localparam int AC    = 3;
    localparam int DEPTH = 256;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ram_init;
    logic        IfReq, IfGnt, IfValid, IfFault;
    logic [31:0] IfAddr, IfData;
    logic        MemReq, MemRW, MemGnt, MemValid, MemFault;
    logic [1:0]  MemSize;
    logic [31:0] MemAddr, MemWData, MemRData;
    logic        RamEnable, RamReadWrite, Busy;
    logic [31:0] RamAddress, RamDataIn, RamDataOut;
    logic [1:0]  RamSize;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_arbiter #(.ACCESS_CYCLES(AC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .IfReq(IfReq), .IfAddr(IfAddr), .IfGnt(IfGnt), .IfValid(IfValid),
        .IfData(IfData), .IfFault(IfFault),
        .MemReq(MemReq), .MemRW(MemRW), .MemSize(MemSize), .MemAddr(MemAddr),
        .MemWData(MemWData), .MemGnt(MemGnt), .MemValid(MemValid),
        .MemRData(MemRData), .MemFault(MemFault),
        .RamEnable(RamEnable), .RamReadWrite(RamReadWrite), .RamAddress(RamAddress),
        .RamDataIn(RamDataIn), .RamSize(RamSize), .RamDataOut(RamDataOut), .Busy(Busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        if (i < 4) return 8'((i + 1) * 17);
        return 8'(i * 37 + 5);
    endfunction

    // ---------------- bench RAM (big-endian, junk above the sized data) ----------------
    logic [7:0] ram [DEPTH];
    logic [7:0] ra;
    assign ra = RamAddress[7:0];

    always_comb begin
        case (RamSize)
            2'b00:   RamDataOut = {24'hDEADBE, ram[ra]};
            2'b01:   RamDataOut = {16'hCAFE, ram[ra], ram[ra + 8'd1]};
            default: RamDataOut = {ram[ra], ram[ra + 8'd1], ram[ra + 8'd2], ram[ra + 8'd3]};
        endcase
    end

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_byte(i);
        end else if (RamEnable && RamReadWrite) begin
            case (RamSize)
                2'b00: ram[ra] <= RamDataIn[7:0];
                2'b01: begin
                    ram[ra]        <= RamDataIn[15:8];
                    ram[ra + 8'd1] <= RamDataIn[7:0];
                end
                default: begin
                    ram[ra]        <= RamDataIn[31:24];
                    ram[ra + 8'd1] <= RamDataIn[23:16];
                    ram[ra + 8'd2] <= RamDataIn[15:8];
                    ram[ra + 8'd3] <= RamDataIn[7:0];
                end
            endcase
        end
    end

    // ---------------- transaction-level model ----------------
    logic [7:0]  sh [DEPTH];
    logic        m_started = 1'b0;
    logic        m_active, m_owner, m_last, m_rw, m_fault;
    int          m_k, m_last_k;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_size;
    logic [31:0] m_if_data, m_mem_data;
    logic        m_if_fault, m_mem_fault;

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_fault(input logic [1:0] size, input logic [31:0] addr);
        int unsigned a;
        int nb;
        a  = addr;
        nb = nbytes(size);
        if (size == 2'b11) return 1'b1;
        if (a % nb != 0) return 1'b1;
        if (longint'(a) + longint'(nb) > longint'(DEPTH)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] sh_read(input logic [1:0] size, input logic [31:0] addr);
        int b;
        logic [31:0] v;
        b = int'(addr[7:0]);
        v = 32'd0;
        for (int i = 0; i < nbytes(size); i++) v = {v[23:0], sh[b + i]};
        return v;
    endfunction

    task automatic apply_response();
        if (m_owner) begin
            m_mem_data  = m_rdata;
            m_mem_fault = m_fault;
        end else begin
            m_if_data   = m_rdata;
            m_if_fault  = m_fault;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            m_started = 1'b1;
            if (ram_init) for (int i = 0; i < DEPTH; i++) sh[i] = init_byte(i);
            if (reset) begin
                m_active = 1'b0; m_last = 1'b0; m_k = 0; m_last_k = 0;
                m_owner = 1'b0; m_fault = 1'b0; m_rw = 1'b0;
                m_addr = 32'd0; m_size = 2'b00; m_wdata = 32'd0; m_rdata = 32'd0;
                m_if_data = 32'd0; m_if_fault = 1'b0;
                m_mem_data = 32'd0; m_mem_fault = 1'b0;
            end else if (m_active) begin
                m_k++;
                if (m_k > m_last_k) m_active = 1'b0;
                else if (m_k == m_last_k) apply_response();
            end else if (IfReq || MemReq) begin
                m_owner  = (IfReq && MemReq) ? !m_last : MemReq;
                m_last   = m_owner;
                m_addr   = m_owner ? MemAddr : IfAddr;
                m_size   = m_owner ? MemSize : 2'b10;
                m_rw     = m_owner && MemRW;
                m_wdata  = MemWData;
                m_fault  = model_fault(m_size, m_addr);
                m_last_k = m_fault ? 0 : AC + 1;
                m_active = 1'b1;
                m_k      = 0;
                m_rdata  = 32'd0;
                if (!m_fault && !m_rw) m_rdata = sh_read(m_size, m_addr);
                if (!m_fault && m_rw) begin
                    for (int i = 0; i < nbytes(m_size); i++)
                        sh[int'(m_addr[7:0]) + i] = 8'(m_wdata >> (8 * (nbytes(m_size) - 1 - i)));
                end
                if (m_fault) apply_response();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic c_on, c_win;
    initial begin
        forever begin
            @(negedge clk);
            if (m_started) begin
                c_on  = !reset && m_active;
                c_win = c_on && !m_fault && (m_k <= AC);
                chk("Busy", 32'(Busy), 32'(c_on));
                chk("IfGnt", 32'(IfGnt), 32'(c_on && m_k == 0 && !m_owner));
                chk("MemGnt", 32'(MemGnt), 32'(c_on && m_k == 0 && m_owner));
                chk("IfValid", 32'(IfValid), 32'(c_on && m_k == m_last_k && !m_owner));
                chk("MemValid", 32'(MemValid), 32'(c_on && m_k == m_last_k && m_owner));
                chk("RamEnable", 32'(RamEnable), 32'(c_win && m_k >= 1));
                if (c_win) begin
                    chk("RamAddress", RamAddress, m_addr);
                    chk("RamSize", 32'(RamSize), 32'(m_size));
                    chk("RamReadWrite", 32'(RamReadWrite), 32'(m_rw));
                    chk("RamDataIn", RamDataIn, m_rw ? m_wdata : 32'd0);
                end else if (reset || (c_on && m_k == m_last_k)) begin
                    chk("RamReadWrite_off", 32'(RamReadWrite), 32'd0);
                end
                if (reset) begin
                    chk("RamAddress_rst", RamAddress, 32'd0);
                    chk("RamDataIn_rst", RamDataIn, 32'd0);
                    chk("RamSize_rst", 32'(RamSize), 32'd0);
                end
                chk("IfData", IfData, reset ? 32'd0 : m_if_data);
                chk("IfFault", 32'(IfFault), reset ? 32'd0 : 32'(m_if_fault));
                chk("MemRData", MemRData, reset ? 32'd0 : m_mem_data);
                chk("MemFault", 32'(MemFault), reset ? 32'd0 : 32'(m_mem_fault));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int n);
        @(negedge clk); #1;
        reset = 1'b1;
        repeat (n) @(negedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (Busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(Busy), 32'd0);
    endtask

    task automatic do_access(input logic is_mem, input logic rw, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output int gnt_c, output int val_c, output int en_cnt,
                             output logic [31:0] data, output logic fault);
        logic g, v;
        gnt_c = -1; val_c = -1; en_cnt = 0; data = 32'd0; fault = 1'b0;
        @(negedge clk); #1;
        if (is_mem) begin
            MemReq = 1'b1; MemRW = rw; MemSize = size; MemAddr = addr; MemWData = wdata;
        end else begin
            IfReq = 1'b1; IfAddr = addr;
        end
        for (int b = 0; b < 40 && val_c < 0; b++) begin
            @(negedge clk);
            g = is_mem ? MemGnt : IfGnt;
            v = is_mem ? MemValid : IfValid;
            if (RamEnable) en_cnt++;
            if (v) begin
                val_c = cyc;
                data  = is_mem ? MemRData : IfData;
                fault = is_mem ? MemFault : IfFault;
            end
            if (g && gnt_c < 0) begin
                gnt_c = cyc;
                #1;
                IfReq  = 1'b0;
                MemReq = 1'b0;
            end
        end
        chk("access_done", 32'(val_c >= 0), 32'd1);
        IfReq  = 1'b0;
        MemReq = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0: a = $urandom();
            1: a = 32'($urandom_range(248, 259));
            default: a = 32'($urandom_range(0, 255));
        endcase
        if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
        return a;
    endfunction

    // ---------------- stimulus ----------------
    int          g_c, v_c, e_c, n, nv, ngr;
    logic [31:0] d;
    logic        f, r_if, r_mem;
    logic [2:0]  order;

    initial begin
        reset = 1'b1; ram_init = 1'b1;
        IfReq = 1'b0; IfAddr = 32'd0;
        MemReq = 1'b0; MemRW = 1'b0; MemSize = 2'b00; MemAddr = 32'd0; MemWData = 32'd0;
        @(negedge clk); #1 ram_init = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        // IF word read of the preloaded word 0
        do_access(1'b0, 1'b0, 2'b10, 32'd0, 32'd0, g_c, v_c, e_c, d, f);
        chk("if_rd_latency", 32'(v_c - g_c), 32'(AC + 1));
        chk("if_rd_en_cycles", 32'(e_c), 32'(AC));
        chk("if_rd_data", d, 32'h1122_3344);
        chk("if_rd_fault", 32'(f), 32'd0);
        wait_idle();

        // MEM byte write then byte read back
        do_access(1'b1, 1'b1, 2'b00, 32'd5, 32'h1234_56A5, g_c, v_c, e_c, d, f);
        chk("wr_data_zero", d, 32'd0);
        chk("wr_en_cycles", 32'(e_c), 32'(AC));
        wait_idle();
        do_access(1'b1, 1'b0, 2'b00, 32'd5, 32'd0, g_c, v_c, e_c, d, f);
        chk("rd_back_byte", d, 32'h0000_00A5);
        wait_idle();

        // Faulting accesses: misaligned half, word crossing the end
        do_access(1'b1, 1'b0, 2'b01, 32'd3, 32'd0, g_c, v_c, e_c, d, f);
        chk("half_mis_same_cycle", 32'(v_c - g_c), 32'd0);
        chk("half_mis_fault", 32'(f), 32'd1);
        chk("half_mis_data", d, 32'd0);
        chk("half_mis_no_en", 32'(e_c), 32'd0);
        wait_idle();
        do_access(1'b1, 1'b0, 2'b10, 32'd254, 32'd0, g_c, v_c, e_c, d, f);
        chk("word_oor_same_cycle", 32'(v_c - g_c), 32'd0);
        chk("word_oor_fault", 32'(f), 32'd1);
        chk("word_oor_no_en", 32'(e_c), 32'd0);
        wait_idle();

        // Word read at 8: full ENABLE window and latency
        do_access(1'b1, 1'b0, 2'b10, 32'd8, 32'd0, g_c, v_c, e_c, d, f);
        chk("word8_latency", 32'(v_c - g_c), 32'(AC + 1));
        chk("word8_en_cycles", 32'(e_c), 32'(AC));
        chk("word8_data", d, {init_byte(8), init_byte(9), init_byte(10), init_byte(11)});
        wait_idle();

        // Reset during ENABLE of an IF read
        @(negedge clk); #1;
        IfReq = 1'b1; IfAddr = 32'd4;
        n = 0;
        @(negedge clk);
        while (!IfGnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_if_gnt", 32'(IfGnt), 32'd1);
        #1 IfReq = 1'b0;
        @(negedge clk);
        chk("rst_in_enable", 32'(RamEnable), 32'd1);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_ram_enable", 32'(RamEnable), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        #1 reset = 1'b0;
        nv = 0;
        for (int i = 0; i < AC + 2; i++) begin
            @(negedge clk);
            if (IfValid) nv++;
        end
        chk("rst_no_ifvalid", 32'(nv), 32'd0);
        do_access(1'b1, 1'b0, 2'b10, 32'd12, 32'd0, g_c, v_c, e_c, d, f);
        chk("post_rst_latency", 32'(v_c - g_c), 32'(AC + 1));
        wait_idle();

        // Both requesters held: round-robin from a fresh reset
        do_reset(1);
        @(negedge clk); #1;
        IfReq = 1'b1; IfAddr = 32'd0;
        MemReq = 1'b1; MemRW = 1'b0; MemSize = 2'b10; MemAddr = 32'd8;
        order = 3'd0; ngr = 0;
        for (int b = 0; b < 60 && ngr < 3; b++) begin
            @(negedge clk);
            chk("single_gnt", 32'(IfGnt && MemGnt), 32'd0);
            if (IfGnt || MemGnt) begin
                order = {order[1:0], MemGnt};
                ngr++;
            end
        end
        #1;
        IfReq = 1'b0; MemReq = 1'b0;
        chk("rr_grants", 32'(ngr), 32'd3);
        chk("rr_order", 32'(order), 32'b101);
        wait_idle();

        // Randomized traffic against the model
        for (int t = 0; t < 150; t++) begin
            @(negedge clk); #1;
            r_if  = 1'($urandom_range(0, 1));
            r_mem = 1'($urandom_range(0, 1));
            IfAddr   = rand_addr();
            MemAddr  = rand_addr();
            MemRW    = 1'($urandom_range(0, 1));
            MemSize  = 2'($urandom_range(0, 3));
            MemWData = $urandom();
            IfReq  = r_if;
            MemReq = r_mem;
            n = 0;
            while ((r_if || r_mem) && n < 40) begin
                @(negedge clk);
                if (IfGnt)  r_if  = 1'b0;
                if (MemGnt) r_mem = 1'b0;
                #1;
                IfReq  = r_if;
                MemReq = r_mem;
                n++;
            end
            chk("rand_granted", 32'(r_if || r_mem), 32'd0);
            IfReq = 1'b0; MemReq = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
